// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline stages: default widths, frame
// geometry helpers and the signed max used by the pooling compare.
package cnn_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_IMG_W  = 128;
    localparam int DEFAULT_IMG_H  = 128;

    // Widest pixel the shared compare handles; narrower pixels are
    // sign-extended into it, which leaves the signed ordering unchanged.
    localparam int MAX_DATA_W = 64;

    typedef logic signed [MAX_DATA_W-1:0] wide_t;

    // Pooled dimension of a frame axis (2x2 window, stride 2).
    function automatic int pool_dim(input int n);
        return n / 2;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int ctr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed maximum; either operand is acceptable on a tie.
    function automatic wide_t smax(input wide_t a, input wide_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for the max-pool stage: one synchronous write port
// and one combinational read port. No reset, so it maps onto distributed RAM.
module pool_line_buf
    import cnn_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store one horizontal partial maximum per pooled column.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_maxpool2d.sv
// Streaming 2x2 / stride-2 max-pool with optional ReLU. Pixels arrive in
// raster order; even rows leave horizontal maxima in the line buffer, odd
// rows combine them with their own pair maxima and emit one pooled value.
module stream_maxpool2d
    import cnn_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int IMG_W   = DEFAULT_IMG_W,
    parameter int IMG_H   = DEFAULT_IMG_H,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     frame_done
);

    localparam int POOL_W = pool_dim(IMG_W);
    localparam int COL_W  = ctr_w(IMG_W);
    localparam int ROW_W  = ctr_w(IMG_H);
    localparam int ADDR_W = ctr_w(POOL_W);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    generate
        if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_geometry
            $error("stream_maxpool2d: IMG_W and IMG_H must be even and at least 2");
        end
    endgenerate

    // DATA_W-wide signed max built on the shared wide compare.
    function automatic logic signed [DATA_W-1:0] max_s(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
        return DATA_W'(smax(wide_t'(a), wide_t'(b)));
    endfunction

    logic [COL_W-1:0]         col_r;
    logic [ROW_W-1:0]         row_r;
    logic signed [DATA_W-1:0] h_r;
    logic signed [DATA_W-1:0] out_data_r;
    logic                     out_valid_r;
    logic                     out_last_r;
    logic                     frame_done_r;

    logic                     accept_s;
    logic                     lb_we_s;
    logic                     emit_s;
    logic                     col_last_s;
    logic                     row_last_s;
    logic [ADDR_W-1:0]        lb_addr_s;
    logic [DATA_W-1:0]        lb_rd_s;
    logic signed [DATA_W-1:0] hmax_s;
    logic signed [DATA_W-1:0] pmax_s;
    logic signed [DATA_W-1:0] result_s;

    // The single-entry output register can take a new value while it drains.
    assign in_ready   = !out_valid_r || out_ready;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign frame_done = frame_done_r;

    // Handshake decode, window position and the compare/ReLU datapath.
    always_comb begin
        accept_s   = in_valid && in_ready && !clear;
        col_last_s = (col_r == COL_MAX);
        row_last_s = (row_r == ROW_MAX);
        lb_addr_s  = ADDR_W'(col_r >> 1'd1);
        lb_we_s    = accept_s && col_r[0] && !row_r[0];
        emit_s     = accept_s && col_r[0] && row_r[0];
        hmax_s     = max_s(h_r, in_data);
        pmax_s     = max_s(DATA_W'(signed'(lb_rd_s)), hmax_s);
        if (RELU_EN && pmax_s[DATA_W-1]) begin
            result_s = {DATA_W{1'b0}};
        end else begin
            result_s = pmax_s;
        end
    end

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (POOL_W),
        .ADDR_W (ADDR_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we_s),
        .waddr (lb_addr_s),
        .wdata (hmax_s),
        .raddr (lb_addr_s),
        .rdata (lb_rd_s)
    );

    // Raster position counters; advance only on an accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (clear) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= {COL_W{1'b0}};
                row_r <= row_last_s ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Hold the even-column pixel until its odd-column partner arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_r <= {DATA_W{1'b0}};
        end else if (clear) begin
            h_r <= {DATA_W{1'b0}};
        end else if (accept_s && !col_r[0]) begin
            h_r <= in_data;
        end
    end

    // Output register: load on window completion, empty on drain or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
        end else if (clear) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (emit_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            out_last_r  <= row_last_s && col_last_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    // One-cycle pulse after the last pooled value of a frame is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= out_valid_r && out_ready && out_last_r && !clear;
        end
    end

endmodule

// File: tb/tb_stream_maxpool2d.sv
module tb_stream_maxpool2d;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [DW-1:0] in_data = '0;

    logic in_ready, out_valid, out_last, frame_done;
    logic signed [DW-1:0] out_data;
    logic in_ready0, out_valid0, out_last0, frame_done0;
    logic signed [DW-1:0] out_data0;

    always #5 clk = ~clk;

    stream_maxpool2d #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .RELU_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_done(frame_done)
    );

    stream_maxpool2d #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .RELU_EN(1'b0)) dut_norelu (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_last(out_last0), .frame_done(frame_done0)
    );

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t exp1[$];
    exp_t exp0[$];
    int   got1[$];
    int   got0[$];
    int   pix[H][W];
    int   idx = 0;
    int   mode = 0;
    int   fd_count = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: remember the frame, and at each window's bottom-right
    // pixel predict the max of its four pixels.
    task automatic model_accept(input int d);
        int r = idx / W;
        int c = idx % W;
        int m;
        pix[r][c] = d;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = pix[r-1][c-1];
            if (pix[r-1][c] > m) m = pix[r-1][c];
            if (pix[r][c-1] > m) m = pix[r][c-1];
            if (pix[r][c] > m) m = pix[r][c];
            exp0.push_back('{m, idx == W*H-1});
            exp1.push_back('{(m < 0) ? 0 : m, idx == W*H-1});
        end
        idx = (idx + 1) % (W*H);
    endtask

    task automatic flush_model();
        exp1.delete();
        exp0.delete();
        idx = 0;
    endtask

    task automatic send(input int d, input bit gaps);
        int t = 0;
        if (gaps) begin
            while ($urandom_range(3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data = DW'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = DW'(d);
        #1;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (in_ready) model_accept(d);
        else chk(1'b0, "accept_timeout", t, 1000);
    endtask

    // kind 0: ramp base+i, kind 1: random full range, kind 2: constant base
    task automatic send_frame(input int kind, input int base, input bit gaps);
        for (int i = 0; i < W*H; i++) begin
            case (kind)
                0: send(base + i, gaps);
                1: send(int'($urandom_range(65535)) - 32768, gaps);
                default: send(base, gaps);
            endcase
        end
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while ((exp1.size() != 0 || exp0.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk(1'b0, "drain_timeout", exp1.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_ramp(input string name, input int base);
        int offs[4] = '{5, 7, 13, 15};
        chk(got1.size() == 4, {name, "_count"}, got1.size(), 4);
        for (int i = 0; i < 4 && i < got1.size(); i++)
            chk(got1[i] == base + offs[i], name, got1[i], base + offs[i]);
    endtask

    // Output monitor: pops the scoreboard on every handshake, checks stall
    // stability, backpressure on in_ready and the frame_done pulse.
    initial begin
        bit stall_prev = 1'b0;
        bit fd_exp = 1'b0;
        logic signed [DW-1:0] hold_d = '0;
        bit hold_l = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !clear) begin
                if (stall_prev) begin
                    chk(out_valid == 1'b1, "stall_valid", int'(out_valid), 1);
                    chk(out_data == hold_d, "stall_data", int'(out_data), int'(hold_d));
                    chk(out_last == hold_l, "stall_last", int'(out_last), int'(hold_l));
                end
                chk(in_ready == (!out_valid || out_ready), "in_ready", int'(in_ready),
                    int'(!out_valid || out_ready));
                chk(in_ready0 == in_ready, "in_ready_match", int'(in_ready0), int'(in_ready));
                chk(frame_done == fd_exp, "frame_done", int'(frame_done), int'(fd_exp));
                chk(frame_done0 == fd_exp, "frame_done_norelu", int'(frame_done0), int'(fd_exp));
                if (frame_done) fd_count++;
                fd_exp = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp1.size() == 0) begin
                        chk(1'b0, "unexpected_out", int'(out_data), 0);
                    end else begin
                        e = exp1.pop_front();
                        chk(int'(out_data) == e.data, "out_data", int'(out_data), e.data);
                        chk(out_last == e.last, "out_last", int'(out_last), int'(e.last));
                        got1.push_back(int'(out_data));
                        fd_exp = out_last;
                    end
                end
                if (out_valid0 && out_ready) begin
                    if (exp0.size() == 0) begin
                        chk(1'b0, "unexpected_out_norelu", int'(out_data0), 0);
                    end else begin
                        e = exp0.pop_front();
                        chk(int'(out_data0) == e.data, "out_data_norelu", int'(out_data0), e.data);
                        chk(out_last0 == e.last, "out_last_norelu", int'(out_last0), int'(e.last));
                        got0.push_back(int'(out_data0));
                    end
                end
                stall_prev = out_valid && !out_ready;
                hold_d = out_data;
                hold_l = out_last;
            end else begin
                stall_prev = 1'b0;
                fd_exp = 1'b0;
            end
        end
    end

    // Downstream ready pattern: always, toggling, or random.
    initial begin
        forever begin
            @(negedge clk);
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(1));
            endcase
        end
    end

    initial begin
        #3;
        chk(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
        chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
        chk(out_data == 16'sd0, "rst_out_data", int'(out_data), 0);
        chk(out_last == 1'b0, "rst_out_last", int'(out_last), 0);
        chk(frame_done == 1'b0, "rst_frame_done", int'(frame_done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp frame, free-flowing output
        mode = 0; got1.delete(); fd_count = 0;
        send_frame(0, 0, 1'b0);
        drain();
        check_ramp("ramp", 0);
        chk(fd_count == 1, "ramp_frame_done_count", fd_count, 1);

        // Same frame with out_ready toggling every cycle
        mode = 1; got1.delete(); fd_count = 0;
        send_frame(0, 0, 1'b0);
        drain();
        check_ramp("ramp_toggle", 0);
        chk(fd_count == 1, "toggle_frame_done_count", fd_count, 1);
        mode = 0;

        // Uniform negative frame: ReLU gives 0, pass-through gives -3
        got1.delete(); got0.delete();
        send_frame(2, -3, 1'b0);
        drain();
        chk(got1.size() == 4 && got0.size() == 4, "neg_count", got1.size(), 4);
        for (int i = 0; i < got1.size() && i < got0.size(); i++) begin
            chk(got1[i] == 0, "neg_relu", got1[i], 0);
            chk(got0[i] == -3, "neg_norelu", got0[i], -3);
        end

        // Signed compare at the negative extreme
        got1.delete(); got0.delete();
        send(-32768, 1'b0); send(-1, 1'b0); send(9, 1'b0); send(4, 1'b0);
        send(-5, 1'b0); send(-2, 1'b0); send(1, 1'b0); send(2, 1'b0);
        for (int i = 0; i < 8; i++) send(int'($urandom_range(65535)) - 32768, 1'b0);
        drain();
        chk(got0.size() == 4 && got0[0] == -1, "signed_window_norelu",
            (got0.size() > 0) ? got0[0] : 99999, -1);
        chk(got1.size() == 4 && got1[0] == 0, "signed_window_relu",
            (got1.size() > 0) ? got1[0] : 99999, 0);
        chk(got0.size() == 4 && got0[1] == 9, "second_window_norelu",
            (got0.size() > 1) ? got0[1] : 99999, 9);

        // Two back-to-back frames
        got1.delete(); fd_count = 0;
        send_frame(0, 0, 1'b0);
        send_frame(0, 100, 1'b0);
        drain();
        begin
            int bb[8] = '{5, 7, 13, 15, 105, 107, 113, 115};
            chk(got1.size() == 8, "b2b_count", got1.size(), 8);
            for (int i = 0; i < 8 && i < got1.size(); i++)
                chk(got1[i] == bb[i], "b2b_data", got1[i], bb[i]);
        end
        chk(fd_count == 2, "b2b_frame_done_count", fd_count, 2);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 6; i++) send(1000 + i, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        flush_model();
        #1;
        chk(out_valid == 1'b0, "midrst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        chk(out_valid == 1'b0, "midrst_out_valid_hold", int'(out_valid), 0);
        rst_n = 1'b1;
        got1.delete();
        send_frame(0, 50, 1'b0);
        drain();
        check_ramp("after_reset", 50);

        // Synchronous clear after nine pixels; the pixel offered with it is dropped
        for (int i = 0; i < 9; i++) send(2000 + i, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 16'sd999;
        flush_model();
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        got1.delete();
        send_frame(0, 20, 1'b0);
        drain();
        check_ramp("after_clear", 20);

        // Random frames with random input gaps and random backpressure
        mode = 2; fd_count = 0;
        for (int f = 0; f < 6; f++) send_frame(1, 0, 1'b1);
        drain();
        mode = 0;
        drain();
        chk(fd_count == 6, "random_frame_done_count", fd_count, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
